// File: rtl/uart_tx_feeder.sv
// Byte FIFO that paces a UART transmitter: pops one byte, pulses start, waits for
// txdone (or a timeout), then enforces an idle gap before the next frame.
module uart_tx_feeder #(
    parameter int DEPTH          = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     start,
    output logic [7:0]               txin,
    input  logic                     txdone,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [7:0]    GAP_LOAD   = 8'(GAP_CYCLES);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t          state_reg, state_next;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg, count_next;
    logic [7:0]      txin_reg;
    logic            start_reg;
    logic            err_reg, err_next;
    logic [7:0]      gap_reg, gap_next;
    logic [TW-1:0]   tmo_reg, tmo_next;
    logic            push, pop;

    assign in_ready    = (count_reg != FULL_COUNT);
    assign push        = in_valid && in_ready;
    assign pop         = (state_reg == S_IDLE) && (count_reg != '0);

    assign start       = start_reg;
    assign txin        = txin_reg;
    assign fifo_count  = count_reg;
    assign busy        = (state_reg != S_IDLE);
    assign timeout_err = err_reg;

    // Storage is left unreset so it maps onto block RAM; the pointers make it invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        tmo_next   = tmo_reg;
        err_next   = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (pop) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                tmo_next   = '0;
                state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (txdone) begin
                    gap_next   = GAP_LOAD;
                    state_next = S_GAP;
                end else if (tmo_reg == TMO_LAST) begin
                    // Frame is abandoned; the byte was already popped and is not retried.
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_reg <= 8'd1) begin
                    gap_next   = 8'd0;
                    state_next = S_IDLE;
                end else begin
                    gap_next = gap_reg - 8'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            txin_reg   <= 8'h00;
            start_reg  <= 1'b0;
            err_reg    <= 1'b0;
            gap_reg    <= 8'd0;
            tmo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            err_reg   <= err_next;
            gap_reg   <= gap_next;
            tmo_reg   <= tmo_next;
            start_reg <= (state_next == S_START);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                txin_reg   <= mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a byte scoreboard is filled on push and
// drained by a monitor on every start pulse.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int GAP   = 4;
    localparam int TMO   = 150;
    localparam int DLY   = 100;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [7:0]             in_data = 8'h00;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic                   start;
    logic [7:0]             txin;
    logic                   txdone = 1'b0;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   busy;
    logic                   timeout_err;

    uart_tx_feeder #(
        .DEPTH(DEPTH),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .start(start),
        .txin(txin),
        .txdone(txdone),
        .fifo_count(fifo_count),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q[$];
    int         mode = 0;        // 0: UART stalled, 1: txdone DLY cycles after start
    bit         done_req = 1'b0;
    int         n_starts = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every start pulse must pop the next expected byte.
    int         cyc = 0;
    int         last_start = -1;
    bit         prev_start = 1'b0;
    logic [7:0] exp_byte;
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_start = 1'b0;
            last_start = -1;
        end else begin
            if (start) begin
                n_starts++;
                chk("start_one_cycle", 32'(prev_start), 0);
                chk("sb_nonempty_at_start", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_byte = q.pop_front();
                    chk("txin_order", txin, exp_byte);
                    $display("frame: txin=0x%02h expected=0x%02h cycle=%0d", txin, exp_byte, cyc);
                end
                if (mode == 1 && last_start >= 0)
                    chk("start_spacing", 32'((cyc - last_start) >= (DLY + GAP + 1)), 1);
                last_start = cyc;
            end
            prev_start = start;
        end
    end

    // UART model: returns txdone DLY cycles after start in mode 1, or once on request.
    int resp_cnt = 0;
    always @(negedge clk) begin
        txdone = 1'b0;
        if (!rst_n) begin
            resp_cnt = 0;
        end else if (done_req) begin
            txdone   = 1'b1;
            done_req = 1'b0;
        end else if (mode == 1 && start) begin
            resp_cnt = DLY;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) txdone = 1'b1;
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        mode     = 0;
        done_req = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        q.push_back(d);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic try_push_rejected(input logic [7:0] d);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic push_wait(input logic [7:0] d);
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("push_wait_bound", 32'(in_ready), 1);
        in_data  = d;
        in_valid = 1'b1;
        q.push_back(d);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim, input string tag);
        int k = 0;
        @(negedge clk);
        while (busy && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int s0;
        int k;

        // Reset state, held in reset
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(timeout_err), 0);
        chk("rst_txin", txin, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte, pushed on the first edge after release
        mode     = 1;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        q.push_back(8'hA5);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("t1_count_after_push", fifo_count, 1);
        chk("t1_no_start_yet", 32'(start), 0);
        @(negedge clk);
        chk("t1_count_before_pop", fifo_count, 1);
        @(negedge clk);
        chk("t1_start_high", 32'(start), 1);
        chk("t1_txin", txin, 8'hA5);
        chk("t1_count_after_pop", fifo_count, 0);
        @(negedge clk);
        chk("t1_start_low", 32'(start), 0);
        chk("t1_busy", 32'(busy), 1);
        wait_idle(300, "t1_idle");
        chk("t1_sb_empty", q.size(), 0);

        // Fill with UART stalled
        do_reset();
        s0 = n_starts;
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("t2_count15", fifo_count, 15);
        chk("t2_ready15", 32'(in_ready), 1);
        push(8'h10);
        chk("t2_count16", fifo_count, 16);
        chk("t2_ready16", 32'(in_ready), 0);
        try_push_rejected(8'h11);
        chk("t2_count_after_reject", fifo_count, 16);
        chk("t2_one_start", n_starts - s0, 1);

        // Push on the same edge as an IDLE pop with three bytes stored
        do_reset();
        push(8'h21);
        push(8'h22);
        push(8'h23);
        push(8'h24);
        @(negedge clk);
        chk("t3_count3", fifo_count, 3);
        chk("t3_busy", 32'(busy), 1);
        done_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 50);
        chk("t3_reached_idle", 32'(busy), 0);
        chk("t3_count_in_idle", fifo_count, 3);
        in_data  = 8'h25;
        in_valid = 1'b1;
        q.push_back(8'h25);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("t3_count_unchanged", fifo_count, 3);
        @(negedge clk);
        chk("t3_start", 32'(start), 1);

        // Stream 40 bytes through the 16-deep FIFO with a 100-cycle UART
        do_reset();
        mode = 1;
        s0   = n_starts;
        for (int i = 0; i < 40; i++) push_wait(8'($urandom_range(0, 255)));
        k = 0;
        while (q.size() != 0 && k < 8000) begin
            @(negedge clk);
            k++;
        end
        chk("t4_sb_drained", q.size(), 0);
        wait_idle(300, "t4_idle");
        chk("t4_start_count", n_starts - s0, 40);
        chk("t4_no_timeout", 32'(timeout_err), 0);

        // Timeout with UART stalled
        do_reset();
        push(8'h5A);
        push(8'h6B);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!start && k < 20);
        chk("t5_first_start", 32'(start), 1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!timeout_err && k < 400);
        chk("t5_timeout_cycles", k, TMO + 1);
        @(negedge clk);
        chk("t5_next_start", 32'(start), 1);
        chk("t5_next_txin", txin, 8'h6B);
        repeat (20) @(negedge clk);
        chk("t5_err_sticky", 32'(timeout_err), 1);

        // Asynchronous reset during WAIT_DONE with five bytes stored
        for (int i = 0; i < 5; i++) push(8'h31 + 8'(i));
        @(negedge clk);
        chk("t6_count5", fifo_count, 5);
        chk("t6_busy", 32'(busy), 1);
        chk("t6_err_before", 32'(timeout_err), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        chk("t6_async_count", fifo_count, 0);
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_start", 32'(start), 0);
        chk("t6_async_txin", txin, 0);
        chk("t6_async_err", 32'(timeout_err), 0);
        chk("t6_async_ready", 32'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s0    = n_starts;
        repeat (30) @(negedge clk);
        chk("t6_no_start_after_release", n_starts - s0, 0);
        chk("t6_count_after_release", fifo_count, 0);
        push(8'h77);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!start && k < 20);
        chk("t6_new_start", 32'(start), 1);
        chk("t6_new_txin", txin, 8'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
